// File: rtl/link_upstream_sched.sv
// Credit-based round-robin scheduler feeding the upstream link flit port, with flush/drain support.
// Optional: define LINK_SCHED_CREDIT_ERR_EN to make err_o flag token-driven credit overflow (sticky until rst).
module link_upstream_sched #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 64,
  parameter int CREDITS     = 16,
  parameter int TOKEN_BATCH = 8,
  parameter int INIT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         link_valid_o,
  output logic [WIDTH-1:0]             link_data_o,
  input  logic                         link_ready_i,
  input  logic                         token_i,
  input  logic                         flush_i,
  output logic                         flush_done_o,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                         err_o
);

  localparam int CW  = $clog2(CREDITS + 1);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int ICW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t          state, state_next;
  logic [ICW-1:0]  init_cnt;
  logic [CW-1:0]   credits;
  logic [CW-1:0]   credits_next;
  logic [CW:0]     credit_sum;
  logic            overflow;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   winner;
  logic            found;
  logic            free;
  logic            grant;
  logic            link_valid;
  logic [WIDTH-1:0] link_data;
  logic [IW-1:0]   grant_id;

  // Rotating priority: scan upward from the requester after the last winner.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign free  = !link_valid || link_ready_i;
  assign grant = (state == S_RUN) && free && (credits != '0) && found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = grant && (winner == IW'(gi));
    end
  endgenerate

  // One spare bit so a token on a nearly full pool can be detected before saturating.
  assign credit_sum   = {1'b0, credits}
                      + (token_i ? (CW+1)'(TOKEN_BATCH) : '0)
                      - {{CW{1'b0}}, grant};
  assign overflow     = credit_sum > (CW+1)'(CREDITS);
  assign credits_next = overflow ? CW'(CREDITS) : credit_sum[CW-1:0];

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (init_cnt == ICW'(INIT_CYCLES - 1)) state_next = S_RUN;
      S_RUN:   if (flush_i) state_next = S_DRAIN;
      S_DRAIN: if (!flush_i) state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      credits    <= CW'(CREDITS);
      last_grant <= IW'(NUM_REQ - 1);
      link_valid <= 1'b0;
      link_data  <= '0;
      grant_id   <= '0;
    end else begin
      state   <= state_next;
      credits <= credits_next;
      if (state == S_INIT) init_cnt <= init_cnt + ICW'(1);
      if (grant) begin
        last_grant <= winner;
        link_valid <= 1'b1;
        link_data  <= req_data_i[winner*WIDTH +: WIDTH];
        grant_id   <= winner;
      end else if (free) begin
        link_valid <= 1'b0;
      end
    end
  end

`ifdef LINK_SCHED_CREDIT_ERR_EN
  logic err;
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (token_i && overflow) err <= 1'b1;
  end
  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

  assign link_valid_o = link_valid;
  assign link_data_o  = link_data;
  assign grant_id_o   = grant_id;
  assign credit_cnt_o = credits;
  assign flush_done_o = (state == S_DRAIN) && !link_valid && (credits == CW'(CREDITS));

endmodule

// File: doc/link_upstream_sched.md
# link_upstream_sched

Credit-based scheduler in front of the DDR upstream link core interface. Arbitrates NUM_REQ core-side requesters round-robin onto the single valid/ready flit port of the upstream link. Tracks link credits: each issued flit consumes one credit, and each returned token pulse restores TOKEN_BATCH credits. Provides a flush/drain sequence used before link reset.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, flit width
- CREDITS, 16, credit pool size; must be a multiple of TOKEN_BATCH
- TOKEN_BATCH, 8, credits returned per token pulse
- INIT_CYCLES, 4, post-reset hold-off before the first grant
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester valid
- req_data_i  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready_o  out  NUM_REQ  one-hot or zero; accept for requester i
- link_valid_o  out  1  registered flit valid to the link core
- link_data_o  out  WIDTH  registered flit data
- link_ready_i  in  1  link core accept
- token_i  in  1  single-cycle pulse, already synchronized to clk
- flush_i  in  1  level; request drain
- flush_done_o  out  1  drain complete
- credit_cnt_o  out  $clog2(CREDITS+1)  current credit count
- grant_id_o  out  $clog2(NUM_REQ)  requester index of the flit in link_data_o
- err_o  out  1  sticky credit overflow (see Configuration)

## Operation
- State machine: INIT -> RUN <-> DRAIN.
  - INIT: counts INIT_CYCLES cycles, then moves to RUN. No grants are issued in INIT.
  - RUN -> DRAIN when flush_i=1.
  - DRAIN -> RUN when flush_i=0.
- Output register is "free" when link_valid_o=0 or link_ready_i=1.
- Grant condition: state=RUN, register free, credits>0, and any req_valid_i set.
- Winner is the first valid requester scanning from (last_grant+1) mod NUM_REQ upward, with wrap-around.
- On grant:
  - req_ready_o[winner]=1.
  - link_data_o and grant_id_o load on the next edge; link_valid_o=1.
  - last_grant<=winner; credits decrement by 1.
- Credit update each cycle: credits + (token_i ? TOKEN_BATCH : 0) - (grant ? 1 : 0).
  - Simultaneous token and grant nets TOKEN_BATCH-1.
  - Result saturates at CREDITS.
- Register free with no grant: link_valid_o<=0, link_data_o holds its value.
- DRAIN: grants stop. A flit already in the output register still completes.
- flush_done_o=1 while state=DRAIN, link_valid_o=0 and credits==CREDITS.
- Credits=0: req_ready_o is all zero. Grants resume the cycle after the token edge.
- Credits are arithmetic in $clog2(CREDITS+1) bits, using one extra bit internally before saturation.

## Timing
- Reset values:
  - state INIT, credits CREDITS, last_grant NUM_REQ-1 (so requester 0 wins first).
  - link_valid_o 0, link_data_o 0, grant_id_o 0, flush_done_o 0, err_o 0, credit_cnt_o CREDITS.
- First possible grant: INIT_CYCLES+1 cycles after rst deasserts.
- req_ready_o is combinational from req_valid_i, link_ready_i, state, credits and last_grant. It has no dependency on link_data_o.
- Accept-to-link latency: 1 cycle. Throughput is 1 flit/cycle while credits>0 and link_ready_i=1.
- flush_done_o and credit_cnt_o are registered-state derived, so they reflect the current cycle's state.
- rst mid-operation: any in-flight flit is dropped (link_valid_o=0 next cycle), credits reload to CREDITS, and the state returns to INIT.

## Configuration
- LINK_SCHED_CREDIT_ERR_EN defined:
  - A token that would push credits above CREDITS sets err_o.
  - err_o stays set until rst.
  - Credits still saturate.
- Undefined: err_o is tied to 0, and overflow only saturates silently.

## Test plan
- Round-robin: all 4 requesters valid, link_ready_i=1, credits 16. Expected:
  - grant_id_o sequence 0,1,2,3,0,1.
  - credit_cnt_o 16 -> 10 after 6 grants.
- Credit exhaustion: constant req 2 valid, no tokens. Expected:
  - 16 flits issued, then req_ready_o=0 with credit_cnt_o=0.
  - token_i pulse -> credit_cnt_o=8, and the grant resumes the next cycle.
- Simultaneous token and grant at credits=5: next credit_cnt_o=12. A token at 16 leaves it at 16; with LINK_SCHED_CREDIT_ERR_EN, err_o=1.
- Backpressure: link_ready_i=0 for 3 cycles with link_valid_o=1. Expected:
  - link_data_o held stable.
  - req_ready_o all zero.
  - No credit consumed.
- Flush: flush_i=1 with one flit pending and credits=7. Expected:
  - The flit completes and grants stop.
  - After one token, credits 15, flush_done_o stays 0.
  - After the next token, credits 16 and flush_done_o=1.
- Reset mid-stream: rst for one cycle while link_valid_o=1 and credits=3. Expected:
  - link_valid_o=0 and credit_cnt_o=16.
  - No grant for INIT_CYCLES cycles, then requester 0 wins first.
